// File: rtl/score_display_scan_pkg.sv
// Shared constants for the score display scanner: digit geometry and
// active-high 7-segment patterns, bit 0 = segment a .. bit 6 = segment g.
package score_display_scan_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_OFF = 7'h00;
endpackage

// File: rtl/score_display_scan_bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment decoder; non-decimal
// nibbles render as "E" and raise invalid_o.
module bcd_to_seg7
  import score_display_scan_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [6:0]          seg_o,
  output logic                invalid_o
);
  always_comb begin
    seg_o     = SEG_E;
    invalid_o = 1'b0;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: invalid_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/score_display_scan.sv
// Snapshots a packed 4-digit BCD score once per frame and multiplexes it onto a
// common-anode 7-segment display with leading-zero blanking and anode gaps.
module score_display_scan
  import score_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0]   points,
  input  logic                             en,
  output logic [6:0]                       seg,
  output logic                             dp,
  output logic [NUM_DIGITS-1:0]            an,
  output logic                             frame_tick,
  output logic                             bcd_err
);
  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_IDLE = ACTIVE_LOW ? 7'h7F : SEG_OFF;
  localparam logic [3:0]       AN_IDLE  = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CNT_W-1:0]               presc_q, presc_d;
  logic [1:0]                     slot_q, slot_d;
  logic [NUM_DIGITS*NIBBLE_W-1:0] shadow_q, shadow_d;
  logic                           primed_q, primed_d;
  logic                           tick_q, tick_d;
  logic [6:0]                     seg_q, seg_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;

  logic [6:0]            pat [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] inv, is_zero, blank, onehot;
  logic                  last_cnt, snap;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_seg7 u_dec (
      .nibble_i  (shadow_q[g*NIBBLE_W +: NIBBLE_W]),
      .seg_o     (pat[g]),
      .invalid_o (inv[g])
    );
    assign is_zero[g] = (shadow_q[g*NIBBLE_W +: NIBBLE_W] == '0);
  end

  // Blanking cascades from the most significant digit; units always show.
  assign blank[3] = BLANK_LZ & is_zero[3];
  assign blank[2] = blank[3] & is_zero[2];
  assign blank[1] = blank[2] & is_zero[1];
  assign blank[0] = 1'b0;

  assign onehot   = 4'b0001 << slot_q;
  assign last_cnt = (presc_q == CNT_LAST);
  assign snap     = en & (~primed_q | (last_cnt & (slot_q == 2'd3)));

  always_comb begin
    presc_d  = presc_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    primed_d = primed_q;
    tick_d   = 1'b0;
    seg_d    = seg_q;
    an_d     = AN_IDLE;
    if (en) begin
      presc_d = last_cnt ? '0 : presc_q + CNT_W'(1);
      if (last_cnt) slot_d = slot_q + 2'd1;
      seg_d = ACTIVE_LOW ? ~pat[slot_q] : pat[slot_q];
      // Count 0 of every slot keeps all anodes dark to avoid ghosting.
      if ((presc_q != '0) && !blank[slot_q]) an_d = ACTIVE_LOW ? ~onehot : onehot;
    end
    if (snap) begin
      shadow_d = points;
      primed_d = 1'b1;
      tick_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      slot_q   <= 2'd0;
      shadow_q <= '0;
      primed_q <= 1'b0;
      tick_q   <= 1'b0;
      seg_q    <= SEG_IDLE;
      an_q     <= AN_IDLE;
    end else begin
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      primed_q <= primed_d;
      tick_q   <= tick_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = ACTIVE_LOW ? 1'b1 : 1'b0;
  assign frame_tick = tick_q;
  assign bcd_err    = |inv;
endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with REFRESH_DIV=4, active-low pins.
module tb_score_display_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] points = 16'h0000;
  logic        en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;
  logic        bcd_err;

  int errors = 0;
  int checks = 0;

  score_display_scan #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .points     (points),
    .en         (en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [15:0] pts);
    rst_n  = 1'b0;
    en     = 1'b0;
    points = pts;
    tick();
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; points = 16'h0123;
    tick(); tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h expected %h", an, 4'hF); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected %h", seg, 7'h7F); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    checks++; if (bcd_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bcd_err); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (frame_tick !== 1'b0 || seg !== 7'h7F || an !== 4'hF)
      begin errors++; $display("FAIL idle_en0: tick=%b seg=%h an=%h expected 0 7f f", frame_tick, seg, an); end
  endtask

  task automatic test_scan_0123();
    int ghost = 0, an3_on = 0, bad_seg = 0, seen1 = 0, seen2 = 0, tick_bad = 0;
    restart(16'h0123);
    tick();
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL scan_first_tick: got %b expected 1", frame_tick); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL scan_first_an: got %h expected f", an); end
    tick();
    checks++; if (an !== 4'b1110 || seg !== 7'h30)
      begin errors++; $display("FAIL scan_units: an=%b seg=%h expected 1110 30", an, seg); end
    for (int k = 3; k <= 17; k++) begin
      int st;
      int sl;
      logic [3:0] exp_an;
      tick();
      st = k - 1;
      sl = (st / 4) % 4;
      if ((st % 4) == 0 || sl == 3) exp_an = 4'hF;
      else exp_an = ~(4'b0001 << sl);
      if (an !== exp_an || $countones(~an) > 1) ghost++;
      if (an[3] == 1'b0) an3_on++;
      if (an == 4'b1110 && seg !== 7'h30) bad_seg++;
      if (an == 4'b1101) begin seen1++; if (seg !== 7'h24) bad_seg++; end
      if (an == 4'b1011) begin seen2++; if (seg !== 7'h79) bad_seg++; end
      if (frame_tick !== (k == 16)) tick_bad++;
    end
    checks++; if (ghost != 0) begin errors++; $display("FAIL scan_antighost: bad cycles=%0d expected 0", ghost); end
    checks++; if (an3_on != 0) begin errors++; $display("FAIL scan_blank_d3: lit cycles=%0d expected 0", an3_on); end
    checks++; if (bad_seg != 0) begin errors++; $display("FAIL scan_seg: bad cycles=%0d expected 0", bad_seg); end
    checks++; if (seen1 != 3 || seen2 != 3)
      begin errors++; $display("FAIL scan_digits_lit: d1=%0d d2=%0d expected 3 3", seen1, seen2); end
    checks++; if (tick_bad != 0) begin errors++; $display("FAIL scan_frame_tick: bad cycles=%0d expected 0", tick_bad); end
  endtask

  task automatic test_zero();
    int bad_an = 0, bad_seg = 0, lit = 0;
    restart(16'h0000);
    tick();
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (an[3:1] !== 3'b111) bad_an++;
      if (an[0] == 1'b0) begin lit++; if (seg !== 7'h40) bad_seg++; end
    end
    checks++; if (bad_an != 0) begin errors++; $display("FAIL zero_upper_an: bad cycles=%0d expected 0", bad_an); end
    checks++; if (bad_seg != 0) begin errors++; $display("FAIL zero_seg: bad cycles=%0d expected 0", bad_seg); end
    checks++; if (lit != 6) begin errors++; $display("FAIL zero_units_lit: got %0d expected 6", lit); end
  endtask

  task automatic test_no_tear();
    int bad_seg = 0, bad_an = 0, lit_old = 0, lit_new = 0, tick_bad = 0;
    restart(16'h0042);
    tick();
    for (int k = 2; k <= 32; k++) begin
      logic [6:0] e0, e1;
      tick();
      if (k == 5) points = 16'h0099;
      e0 = (k <= 16) ? 7'h24 : 7'h10;
      e1 = (k <= 16) ? 7'h19 : 7'h10;
      if (an == 4'b1110) begin if (seg !== e0) bad_seg++; if (k <= 16) lit_old++; else lit_new++; end
      if (an == 4'b1101) begin if (seg !== e1) bad_seg++; if (k <= 16) lit_old++; else lit_new++; end
      if (an[3:2] !== 2'b11) bad_an++;
      if (frame_tick !== (k == 16 || k == 32)) tick_bad++;
    end
    checks++; if (bad_seg != 0) begin errors++; $display("FAIL tear_seg: bad cycles=%0d expected 0", bad_seg); end
    checks++; if (bad_an != 0) begin errors++; $display("FAIL tear_blank: bad cycles=%0d expected 0", bad_an); end
    checks++; if (lit_old != 6 || lit_new != 6)
      begin errors++; $display("FAIL tear_lit: old=%0d new=%0d expected 6 6", lit_old, lit_new); end
    checks++; if (tick_bad != 0) begin errors++; $display("FAIL tear_tick: bad cycles=%0d expected 0", tick_bad); end
  endtask

  task automatic test_bad_digit();
    int bad_seg = 0, seen_e = 0, seen_z = 0, err_bad = 0, an3_on = 0;
    restart(16'h0A05);
    tick();
    checks++; if (bcd_err !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b expected 1", bcd_err); end
    points = 16'h0105;
    for (int k = 2; k <= 16; k++) begin
      tick();
      if (an == 4'b1011) begin seen_e++; if (seg !== 7'h06) bad_seg++; end
      if (an == 4'b1101) begin seen_z++; if (seg !== 7'h40) bad_seg++; end
      if (an == 4'b1110 && seg !== 7'h12) bad_seg++;
      if (an[3] == 1'b0) an3_on++;
      if (k < 16 && bcd_err !== 1'b1) err_bad++;
    end
    checks++; if (bad_seg != 0) begin errors++; $display("FAIL bad_seg: bad cycles=%0d expected 0", bad_seg); end
    checks++; if (seen_e != 3 || seen_z != 3 || an3_on != 0)
      begin errors++; $display("FAIL bad_lit: e=%0d zero=%0d d3=%0d expected 3 3 0", seen_e, seen_z, an3_on); end
    checks++; if (err_bad != 0) begin errors++; $display("FAIL bad_err_sticky: bad cycles=%0d expected 0", err_bad); end
    checks++; if (bcd_err !== 1'b0 || frame_tick !== 1'b1)
      begin errors++; $display("FAIL bad_err_clear: err=%b tick=%b expected 0 1", bcd_err, frame_tick); end
  endtask

  task automatic test_en_pause();
    int hold_bad = 0;
    restart(16'h1234);
    repeat (10) tick();
    en = 1'b0;
    tick();
    checks++; if (an !== 4'hF || frame_tick !== 1'b0 || seg !== 7'h24)
      begin errors++; $display("FAIL pause_outputs: an=%h tick=%b seg=%h expected f 0 24", an, frame_tick, seg); end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (an !== 4'hF || frame_tick !== 1'b0 || seg !== 7'h24) hold_bad++;
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL pause_hold: bad cycles=%0d expected 0", hold_bad); end
    en = 1'b1;
    tick();
    checks++; if (an !== 4'b1011 || seg !== 7'h24)
      begin errors++; $display("FAIL resume_slot2: an=%b seg=%h expected 1011 24", an, seg); end
    tick();
    checks++; if (an !== 4'b1011) begin errors++; $display("FAIL resume_count3: an=%b expected 1011", an); end
    tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL resume_gap: an=%b expected 1111", an); end
    tick();
    checks++; if (an !== 4'b0111 || seg !== 7'h79)
      begin errors++; $display("FAIL resume_slot3: an=%b seg=%h expected 0111 79", an, seg); end
    tick();
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL resume_no_extra_tick: got %b expected 0", frame_tick); end
    tick();
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL resume_wrap_tick: got %b expected 1", frame_tick); end
  endtask

  task automatic test_reset_mid();
    restart(16'h0A05);
    repeat (6) tick();
    checks++; if (bcd_err !== 1'b1 || an === 4'hF)
      begin errors++; $display("FAIL mid_pre: err=%b an=%h expected 1 and a lit anode", bcd_err, an); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'hF || seg !== 7'h7F || bcd_err !== 1'b0 || frame_tick !== 1'b0)
      begin errors++; $display("FAIL mid_reset: an=%h seg=%h err=%b tick=%b expected f 7f 0 0", an, seg, bcd_err, frame_tick); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (frame_tick !== 1'b1 || bcd_err !== 1'b1)
      begin errors++; $display("FAIL mid_resnap: tick=%b err=%b expected 1 1", frame_tick, bcd_err); end
  endtask

  initial begin
    test_reset();
    test_scan_0123();
    test_zero();
    test_no_tear();
    test_bad_digit();
    test_en_pause();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
